ir_pulse_conditioner: RTL

IR_PULSE_CONDITIONER -- requirements
Module: ir_pulse_conditioner

---
 rtl/vcr_ir_pkg.sv | 51 +++++
 rtl/ir_glitch_filter.sv | 42 ++++
 rtl/ir_pulse_conditioner.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vcr_ir_pkg.sv
// rtl/vcr_ir_pkg.sv - shared types, window constants and classifier for the IR pulse conditioner
package vcr_ir_pkg;

  typedef enum logic [1:0] {
    SYM_ZERO  = 2'b00,
    SYM_ONE   = 2'b01,
    SYM_START = 2'b10,
    SYM_ERROR = 2'b11
  } sym_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MARK  = 2'b01,
    ST_SPACE = 2'b10,
    ST_STUCK = 2'b11
  } ir_state_t;

  localparam int              LEN_W   = 8;
  localparam logic [LEN_W-1:0] LEN_MAX = 8'd255;

  // Classification windows in ticks, bounds inclusive.
  localparam logic [LEN_W-1:0] START_MARK_MIN  = 8'd80;
  localparam logic [LEN_W-1:0] START_MARK_MAX  = 8'd100;
  localparam logic [LEN_W-1:0] START_SPACE_MIN = 8'd40;
  localparam logic [LEN_W-1:0] START_SPACE_MAX = 8'd50;
  localparam logic [LEN_W-1:0] BIT_MARK_MIN    = 8'd4;
  localparam logic [LEN_W-1:0] BIT_MARK_MAX    = 8'd8;
  localparam logic [LEN_W-1:0] ZERO_SPACE_MIN  = 8'd4;
  localparam logic [LEN_W-1:0] ZERO_SPACE_MAX  = 8'd8;
  localparam logic [LEN_W-1:0] ONE_SPACE_MIN   = 8'd14;
  localparam logic [LEN_W-1:0] ONE_SPACE_MAX   = 8'd20;

  // First matching window wins; anything unmatched is an error symbol.
  function automatic sym_code_t classify(input logic [LEN_W-1:0] mark_len,
                                         input logic [LEN_W-1:0] space_len);
    sym_code_t code;
    if (mark_len >= START_MARK_MIN && mark_len <= START_MARK_MAX &&
        space_len >= START_SPACE_MIN && space_len <= START_SPACE_MAX)
      code = SYM_START;
    else if (mark_len >= BIT_MARK_MIN && mark_len <= BIT_MARK_MAX &&
             space_len >= ZERO_SPACE_MIN && space_len <= ZERO_SPACE_MAX)
      code = SYM_ZERO;
    else if (mark_len >= BIT_MARK_MIN && mark_len <= BIT_MARK_MAX &&
             space_len >= ONE_SPACE_MIN && space_len <= ONE_SPACE_MAX)
      code = SYM_ONE;
    else
      code = SYM_ERROR;
    return code;
  endfunction

endpackage

// File: rtl/ir_glitch_filter.sv
// rtl/ir_glitch_filter.sv - 2-flop synchronizer plus persistence filter for the raw IR line
//   clk   : system tick clock
//   rst_n : asynchronous active-low reset, forces idle (high) level
//   ir    : raw IR line, asynchronous to clk
//   level : filtered level, changes GLITCH_TICKS cycles after the synchronized input settles
module ir_glitch_filter #(
  parameter int GLITCH_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ir,
  output logic level
);

  localparam int            CW       = (GLITCH_TICKS > 1) ? $clog2(GLITCH_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GLITCH_TICKS - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      level  <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], ir};
      // Any sample that agrees with the current level restarts the run.
      if (sync_q[1] != level) begin
        if (cnt_q == CNT_LAST) begin
          level <= sync_q[1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ir_pulse_conditioner.sv
// rtl/ir_pulse_conditioner.sv - IR mark/space decoder with symbol FIFO
//   clk       : 10 kHz tick clock
//   rst_n     : asynchronous active-low reset
//   IR        : raw demodulated IR line, idle high, low = mark
//   sym_valid : symbol FIFO non-empty
//   sym_ready : consumer takes the head symbol when high with sym_valid
//   sym_code  : head symbol (ZERO/ONE/START/ERROR)
//   line_idle : high while no frame is in progress
//   overflow  : sticky, a symbol was dropped on a full FIFO
module ir_pulse_conditioner
  import vcr_ir_pkg::*;
#(
  parameter int GLITCH_TICKS = 2,
  parameter int IDLE_TICKS   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       IR,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [1:0] sym_code,
  output logic       line_idle,
  output logic       overflow
);

  // Space count at which one more tick would reach IDLE_TICKS.
  localparam logic [LEN_W-1:0] SPACE_LAST = LEN_W'(IDLE_TICKS - 1);
  localparam logic [LEN_W-1:0] MARK_LAST  = LEN_MAX - 8'd1;

  logic level;
  logic level_d;
  logic fall;
  logic rise;

  ir_glitch_filter #(
    .GLITCH_TICKS(GLITCH_TICKS)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .ir    (IR),
    .level (level)
  );

  assign fall = level_d & ~level;
  assign rise = ~level_d & level;

  // ---------------- FSM ----------------
  ir_state_t        state_q, state_n;
  logic [LEN_W-1:0] cnt_q, cnt_n;
  logic [LEN_W-1:0] mark_q, mark_n;
  logic             push;
  sym_code_t        push_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mark_q  <= '0;
      level_d <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      mark_q  <= mark_n;
      level_d <= level;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    mark_n    = mark_q;
    push      = 1'b0;
    push_code = SYM_ZERO;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_n = ST_MARK;
          cnt_n   = 8'd1;
        end
      end
      ST_MARK: begin
        if (rise) begin
          mark_n  = cnt_q;
          state_n = ST_SPACE;
          cnt_n   = 8'd1;
        end else if (cnt_q == MARK_LAST) begin
          // Line held low too long: report once, then wait for release.
          cnt_n     = LEN_MAX;
          push      = 1'b1;
          push_code = SYM_ERROR;
          state_n   = ST_STUCK;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      ST_SPACE: begin
        if (fall) begin
          push      = 1'b1;
          push_code = classify(mark_q, cnt_q);
          state_n   = ST_MARK;
          cnt_n     = 8'd1;
        end else if (cnt_q == SPACE_LAST) begin
          // Frame over; the pending mark was the stop mark and is discarded.
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt_q != LEN_MAX) begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      ST_STUCK: begin
        if (rise) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    line_idle = (state_q == ST_IDLE);
  end

  // ---------------- 2-entry symbol FIFO ----------------
  logic [1:0] mem_q [2];
  logic       rd_q;
  logic       wr_q;
  logic [1:0] count_q;
  logic       ovf_q;
  logic       full;
  logic       pop;
  logic       do_push;

  assign full    = (count_q == 2'd2);
  assign pop     = sym_valid & sym_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= 2'b00;
      mem_q[1] <= 2'b00;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_code;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign sym_valid = (count_q != 2'd0);
  assign sym_code  = mem_q[rd_q];
  assign overflow  = ovf_q;

endmodule
